array_result_collector: RTL

//  Receives the PE_NUMBER_I parallel m_axis_down result streams of the linear

---
 rtl/array_result_collector_pkg.sv | 14 +
 rtl/array_result_collector_lane_hold.sv | 56 +++++
 rtl/array_result_collector.sv | 137 +++++++++++++
 3 files changed

// File: rtl/array_result_collector_pkg.sv
// Shared stream-block definitions: collector FSM states and index-width helper.
package array_result_collector_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } arc_state_e;

    // Index width for an n-entry selector, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/array_result_collector_lane_hold.sv
// One-entry AXI-stream hold for a single array lane, with external clear.
module axis_lane_hold
    import array_result_collector_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int USER_WIDTH = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_clr,
    input  logic [DATA_WIDTH-1:0] i_tdata,
    input  logic                  i_tvalid,
    output logic                  o_tready,
    input  logic                  i_tlast,
    input  logic [USER_WIDTH-1:0] i_tuser,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    output logic [USER_WIDTH-1:0] o_user,
    output logic                  o_nxt_valid,
    output logic                  o_nxt_last,
    output logic [USER_WIDTH-1:0] o_nxt_user
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_last;
    logic [USER_WIDTH-1:0] r_user;
    logic                  w_cap;

    assign o_tready = ~r_valid & ~i_rst & i_en;
    assign w_cap    = i_tvalid & o_tready;

    // Post-edge view, so the collector can judge a beat on the edge that completes it.
    assign o_nxt_valid = r_valid | w_cap;
    assign o_nxt_last  = w_cap ? i_tlast : r_last;
    assign o_nxt_user  = w_cap ? i_tuser : r_user;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_valid <= 1'b0;
        end else if (w_cap) begin
            r_valid <= 1'b1;
            r_data  <= i_tdata;
            r_last  <= i_tlast;
            r_user  <= i_tuser;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;
    assign o_user  = r_user;

endmodule

// File: rtl/array_result_collector.sv
// Serialises PE_NUMBER_I aligned lane words into one AXI-stream, lane 0 first,
// and flags cross-lane tlast/tuser disagreement.
module array_result_collector
    import array_result_collector_pkg::*;
#(
    parameter int PE_NUMBER_I = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int USER_ENABLE = 0,
    parameter int USER_WIDTH  = 1,
    parameter int FCNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH*PE_NUMBER_I-1:0] s_axis_tdata,
    input  logic [PE_NUMBER_I-1:0]           s_axis_tvalid,
    output logic [PE_NUMBER_I-1:0]           s_axis_tready,
    input  logic [PE_NUMBER_I-1:0]           s_axis_tlast,
    input  logic [USER_WIDTH*PE_NUMBER_I-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast,
    output logic [USER_WIDTH-1:0]            m_axis_tuser,
    output logic                             err_unaligned_last,
    output logic                             err_user_flag,
    output logic [FCNT_WIDTH-1:0]            frame_count
);

    localparam int unsigned IW = idx_width(PE_NUMBER_I);
    localparam logic [IW-1:0] LAST_IDX = IW'(PE_NUMBER_I - 1);

    arc_state_e             r_state, w_state_nxt;
    logic [IW-1:0]          r_idx, w_idx_nxt;
    logic                   w_collect, w_clr, w_enter_emit;
    logic                   w_last_mixed, w_user_mixed;
    logic                   r_err_last, r_err_user;
    logic [FCNT_WIDTH-1:0]  r_fcnt;

    logic [PE_NUMBER_I-1:0] w_hold_valid, w_hold_last, w_nxt_valid, w_nxt_last;
    logic [DATA_WIDTH-1:0]  w_hold_data [PE_NUMBER_I];
    logic [USER_WIDTH-1:0]  w_hold_user [PE_NUMBER_I];
    logic [USER_WIDTH-1:0]  w_nxt_user  [PE_NUMBER_I];

    assign w_collect = (r_state == COLLECT);

    for (genvar gi = 0; gi < PE_NUMBER_I; gi++) begin : g_lane
        axis_lane_hold #(
            .DATA_WIDTH (DATA_WIDTH),
            .USER_WIDTH (USER_WIDTH)
        ) u_hold (
            .i_clk       (clk),
            .i_rst       (rst),
            .i_en        (w_collect),
            .i_clr       (w_clr),
            .i_tdata     (s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH]),
            .i_tvalid    (s_axis_tvalid[gi]),
            .o_tready    (s_axis_tready[gi]),
            .i_tlast     (s_axis_tlast[gi]),
            .i_tuser     (s_axis_tuser[gi*USER_WIDTH +: USER_WIDTH]),
            .o_valid     (w_hold_valid[gi]),
            .o_data      (w_hold_data[gi]),
            .o_last      (w_hold_last[gi]),
            .o_user      (w_hold_user[gi]),
            .o_nxt_valid (w_nxt_valid[gi]),
            .o_nxt_last  (w_nxt_last[gi]),
            .o_nxt_user  (w_nxt_user[gi])
        );
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_clr         = 1'b0;
        w_enter_emit  = 1'b0;
        m_axis_tvalid = 1'b0;
        case (r_state)
            COLLECT: begin
                if (&w_nxt_valid) begin
                    w_state_nxt  = EMIT;
                    w_enter_emit = 1'b1;
                end
            end
            EMIT: begin
                m_axis_tvalid = 1'b1;
                if (m_axis_tready) begin
                    if (r_idx == LAST_IDX) begin
                        w_idx_nxt   = '0;
                        w_clr       = 1'b1;
                        w_state_nxt = COLLECT;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            default: w_state_nxt = COLLECT;
        endcase
    end

    always_comb begin
        w_last_mixed = (|w_nxt_last) & ~(&w_nxt_last);
        w_user_mixed = 1'b0;
        for (int unsigned i = 1; i < PE_NUMBER_I; i++) begin
            if (w_nxt_user[i] != w_nxt_user[0]) w_user_mixed = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= COLLECT;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_last <= 1'b0;
            r_err_user <= 1'b0;
            r_fcnt     <= '0;
        end else begin
            if (w_enter_emit && w_last_mixed) r_err_last <= 1'b1;
            if (USER_ENABLE != 0 && w_enter_emit && w_user_mixed) r_err_user <= 1'b1;
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) r_fcnt <= r_fcnt + 1'b1;
        end
    end

    // A mixed-tlast beat has AND(hold_last)=0, so it never emits tlast.
    assign m_axis_tdata       = w_hold_data[r_idx];
    assign m_axis_tlast       = m_axis_tvalid & (r_idx == LAST_IDX) & (&w_hold_last);
    assign m_axis_tuser       = (USER_ENABLE != 0) ? w_hold_user[r_idx] : '0;
    assign err_unaligned_last = r_err_last;
    assign err_user_flag      = r_err_user;
    assign frame_count        = r_fcnt;

endmodule
